// File: rtl/sr_bank_writer.sv
// Command-side driver for a bank of N SR flip-flops: scans the bank one bit per
// cycle, issues set/reset only where q differs from the latched target, then checks.
module sr_bank_writer #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   target,
  input  logic [N-1:0]   q_in,
  output logic [2*N-1:0] sr_bus,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic           match,
  output logic [CW-1:0]  nchg
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, CHECK} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [N-1:0]   target_r;
  logic           set_bit;
  logic           rst_bit;
  logic [2*N-1:0] cmd_bus;

  // Set and reset are mutually exclusive by construction, so 11 can never be formed.
  always_comb begin
    set_bit = target_r[idx] & ~q_in[idx];
    rst_bit = ~target_r[idx] & q_in[idx];
    cmd_bus = '0;
    cmd_bus[{idx, 1'b0} +: 2] = {set_bit, rst_bit};
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      target_r <= '0;
      sr_bus   <= '0;
      done     <= 1'b0;
      match    <= 1'b0;
      nchg     <= '0;
    end else begin
      sr_bus <= '0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target_r <= target;
            idx      <= '0;
            nchg     <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          sr_bus <= cmd_bus;
          if (set_bit | rst_bit) begin
            nchg <= nchg + CW'(1);
          end
          if (idx == LAST_IDX) begin
            state <= FLUSH;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        // Gives the bank one edge to sample the last bit's command before the check.
        FLUSH: begin
          state <= CHECK;
        end
        CHECK: begin
          match <= (q_in == target_r);
          done  <= 1'b1;
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Directed bench for sr_bank_writer with a behavioural SR flip-flop bank on the
// command bus and an optional stuck-at-0 mask on the feedback.
module tb_sr_bank_writer;

  localparam int N  = 8;
  localparam int CW = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   target;
  logic [N-1:0]   q_in;
  logic [2*N-1:0] sr_bus;
  logic           ready;
  logic           busy;
  logic           done;
  logic           match;
  logic [CW-1:0]  nchg;

  logic [N-1:0]   bank;
  logic [N-1:0]   stuck_mask;
  logic           preload_en;
  logic [N-1:0]   preload_val;

  int checks;
  int errors;

  sr_bank_writer #(.N(N), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .q_in   (q_in),
    .sr_bus (sr_bus),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .match  (match),
    .nchg   (nchg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SR bank; deliberately unaffected by rst so an abort leaves it as is.
  always @(posedge clk) begin
    if (preload_en) begin
      bank <= preload_val;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sr_bus[2*i +: 2] == 2'b10) bank[i] <= 1'b1;
        else if (sr_bus[2*i +: 2] == 2'b01) bank[i] <= 1'b0;
      end
    end
  end

  assign q_in = bank & ~stuck_mask;

  task automatic preload(input logic [N-1:0] v);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_val = v;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  task automatic run_write(input string name, input logic [N-1:0] tgt,
                           input logic [N-1:0] set_mask, input logic [N-1:0] rst_mask,
                           input logic [CW-1:0] exp_nchg, input logic exp_match,
                           input logic [N-1:0] exp_bank, input int inject_k);
    logic [2*N-1:0] exp_bus;
    @(negedge clk);
    start  = 1'b1;
    target = tgt;
    @(posedge clk);
    #1;
    start  = 1'b0;
    target = ~tgt;
    checks++;
    if (busy !== 1'b1 || nchg !== '0) begin
      errors++;
      $display("[TB] FAIL %s accept: busy=%b nchg=%0d, required busy=1 nchg=0", name, busy, nchg);
    end
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      exp_bus = '0;
      if (set_mask[k]) exp_bus[2*k +: 2] = 2'b10;
      else if (rst_mask[k]) exp_bus[2*k +: 2] = 2'b01;
      checks++;
      if (sr_bus !== exp_bus || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s bit%0d: sr_bus=%h busy=%b done=%b, required sr_bus=%h busy=1 done=0",
                 name, k, sr_bus, busy, done, exp_bus);
      end
      if (k == inject_k) begin
        start  = 1'b1;
        target = 8'hFF;
      end
      if (k == inject_k + 1) begin
        start  = 1'b0;
        target = ~tgt;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (sr_bus !== '0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s flush: sr_bus=%h done=%b, required sr_bus=0 done=0", name, sr_bus, done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || match !== exp_match || nchg !== exp_nchg || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done: done=%b match=%b nchg=%0d ready=%b, required done=1 match=%b nchg=%0d ready=1",
               name, done, match, nchg, ready, exp_match, exp_nchg);
    end
    checks++;
    if (bank !== exp_bank) begin
      errors++;
      $display("[TB] FAIL %s bank: bank=%h, required %h", name, bank, exp_bank);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (sr_bus !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || nchg !== '0 || match !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: sr_bus=%h ready=%b busy=%b done=%b nchg=%0d match=%b, required 0/1/0/0/0/0",
               sr_bus, ready, busy, done, nchg, match);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sr_bus !== '0 || ready !== 1'b1 || done !== 1'b0 || nchg !== '0) begin
        errors++;
        $display("[TB] FAIL idle_hold%0d: sr_bus=%h ready=%b done=%b nchg=%0d, required 0/1/0/0",
                 c, sr_bus, ready, done, nchg);
      end
    end
  endtask

  task automatic test_full_write();
    preload(8'h00);
    run_write("full_a5", 8'hA5, 8'hA5, 8'h00, 4'd4, 1'b1, 8'hA5, -10);
  endtask

  task automatic test_partial_update();
    preload(8'hF0);
    run_write("partial_3c", 8'h3C, 8'h0C, 8'hC0, 4'd4, 1'b1, 8'h3C, -10);
  endtask

  task automatic test_noop_write();
    preload(8'h5A);
    run_write("noop_5a", 8'h5A, 8'h00, 8'h00, 4'd0, 1'b1, 8'h5A, -10);
  endtask

  task automatic test_start_busy();
    preload(8'h00);
    run_write("busy_01", 8'h01, 8'h01, 8'h00, 4'd1, 1'b1, 8'h01, 2);
    run_write("b2b_81", 8'h81, 8'h80, 8'h00, 4'd1, 1'b1, 8'h81, -10);
  endtask

  task automatic test_mismatch();
    preload(8'h00);
    stuck_mask = 8'h10;
    run_write("stuck4", 8'h10, 8'h10, 8'h00, 4'd1, 1'b0, 8'h10, -10);
    stuck_mask = 8'h00;
  endtask

  task automatic test_abort();
    bit done_seen;
    preload(8'h00);
    @(negedge clk);
    start  = 1'b1;
    target = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sr_bus !== 16'h0080) begin
      errors++;
      $display("[TB] FAIL abort_pre: sr_bus=%h, required 0080", sr_bus);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sr_bus !== '0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || nchg !== '0) begin
      errors++;
      $display("[TB] FAIL abort_reset: sr_bus=%h ready=%b busy=%b done=%b nchg=%0d, required 0/1/0/0/0",
               sr_bus, ready, busy, done, nchg);
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < N + 4; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || sr_bus !== '0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: activity after abort=%b, required 0", done_seen);
    end
    checks++;
    if (bank !== 8'h07) begin
      errors++;
      $display("[TB] FAIL abort_bank: bank=%h, required 07", bank);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    target      = '0;
    stuck_mask  = '0;
    preload_en  = 1'b0;
    preload_val = '0;
    bank        = '0;
    test_reset();
    test_full_write();
    test_partial_update();
    test_noop_write();
    test_start_busy();
    test_mismatch();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_bank_writer.md
Name: sr_bank_writer

Overview:
- Command-side driver for a bank of N SR flip-flops that use the team's 2-bit sr encoding: 00 hold, 01 reset, 10 set, 11 forbidden.
- On a start request it latches a target word. It then scans the bank one bit per cycle and issues set/reset commands only to bits whose fed-back q differs from the target.
- After the scan it checks the bank against the target and reports the result.
- Sits between control logic and an N-wide SR flip-flop bank. Guarantees the forbidden 11 code is never driven.

Parameters:
- N, 8, number of SR flip-flops in the driven bank (N >= 2).
- CW, 4, width of the change counter; must satisfy 2^CW > N.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to write target into the bank; sampled only when ready=1.
- target  input  N  desired bank contents; latched on the accepted start.
- q_in  input  N  feedback of the bank's q outputs.
- sr_bus  output  2N  registered commands; bits [2i+1:2i] drive flop i as {s,r}.
- ready  output  1  high when the FSM is IDLE; start is accepted only then.
- busy  output  1  high whenever the FSM is not IDLE (inverse of ready).
- done  output  1  registered one-cycle pulse at the end of a write.
- match  output  1  registered result of the final check: 1 means q_in equalled the latched target.
- nchg  output  CW  number of non-hold commands issued by the current or last write.

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, idx=0, target_r=0.
  - sr_bus=all 00, done=0, match=0, nchg=0.
  - Reset mid-operation aborts the write at once: sr_bus is forced to hold immediately, no done pulse is produced, and bank contents are left as they are.
- FSM states: IDLE, SCAN, FLUSH, CHECK.
- IDLE:
  - ready=1, sr_bus=all 00.
  - On start=1 at an edge: target_r<=target, idx<=0, nchg<=0, state<=SCAN.
  - start=0 keeps the FSM in IDLE.
- SCAN, at each edge with current idx=i:
  - sr_bus<=all 00 except field i.
  - Field i = 10 if target_r[i]=1 and q_in[i]=0.
  - Field i = 01 if target_r[i]=0 and q_in[i]=1.
  - Field i = 00 otherwise.
  - nchg increments by 1 whenever field i is non-zero.
  - If i=N-1: state<=FLUSH. Otherwise idx<=i+1.
- FLUSH: at the edge, sr_bus<=all 00 and state<=CHECK. At this same edge the bank samples the command for bit N-1.
- CHECK: at the edge, match<=(q_in==target_r), done<=1 for exactly one cycle, state<=IDLE, idx<=0.
- At most one field of sr_bus is non-zero in any cycle. The value 11 never appears in any field.
- Latency:
  - Accepted start at edge E0 produces the command for bit i on sr_bus after edge E(i+1).
  - done is high after edge E(N+2).
  - Total: N+2 cycles from accept to done.
- Ignored inputs while busy:
  - start while busy=1 is ignored, with no queuing.
  - Changes on target while busy are ignored; target_r is used.
- Back-to-back: start asserted in the cycle done is high is accepted, because the FSM is already IDLE.
- Hold rules:
  - match and nchg hold their values until the next accepted start.
  - At the next accepted start, nchg clears to 0 and match holds until the next CHECK.
- Width: nchg wraps modulo 2^CW. The CW rule above makes wrap unreachable.
- A bit already equal to its target receives hold only. A target equal to the bank gives nchg=0 and match=1.

Test Plan:
- Reset then idle: assert rst mid-cycle -> sr_bus=0, ready=1, done=0, nchg=0 immediately. Release rst, hold start=0 for 5 cycles -> outputs unchanged.
- Full write, N=8, bank all 0, start with target=8'hA5 -> set commands (10) only on bits 0,2,5,7, in cycles 1,3,6,8 after accept. done at cycle 10 with match=1, nchg=4.
- Partial update: bank=8'hF0, target=8'h3C -> reset (01) on bits 6,7 and set (10) on bits 2,3, all other fields 00. nchg=4, match=1.
- No-op write: bank=8'h5A, target=8'h5A -> sr_bus stays 0 throughout, done after 10 cycles, nchg=0, match=1.
- Start while busy: second start with target=8'hFF at cycle 3 of a write of 8'h01 -> ignored. Final bank=8'h01. Next start in the done cycle is accepted.
- Mismatch and abort:
  - Bench forces q_in bit 4 stuck at 0, target=8'h10 -> done with match=0, nchg=1.
  - rst asserted at scan idx=4 -> sr_bus=0 at once and no done pulse.
